// File: rtl/clk_heartbeat_tx.sv
// Heartbeat transmitter: a Gray-coded counter advanced at a programmable rate.
// The far end only ever sees single-bit code changes. On disable the counter
// keeps stepping at the same rate until it reaches 0, then parks, so the
// receiver always comes to rest on code 0.
module clk_heartbeat_tx #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             active,
   output logic             wrap_pulse
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic [DIV_W-1:0] r_presc;
   logic             r_active;
   logic             r_wrap;

   logic             w_tick;
   logic             w_inc;
   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   logic [DIV_W-1:0] w_presc_next;
   logic             w_wrap_next;

   // Prescaler countdown and counter step; the counter only moves while
   // running or draining, and only when the countdown has expired.
   always_comb begin
      w_tick       = (r_state != IDLE);
      w_inc        = w_tick && (r_presc == '0);
      w_bin_next   = r_bin;
      w_presc_next = r_presc;
      w_wrap_next  = 1'b0;
      if (w_inc) begin
         w_bin_next   = r_bin + 1'b1;
         w_presc_next = div;
         w_wrap_next  = &r_bin;
      end else if (w_tick) begin
         w_presc_next = r_presc - 1'b1;
      end
   end

   // Gray encoding of the next count, so gray_out moves on the same edge as bin_out.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
         assign w_gray_next[gi] = w_bin_next[gi] ^ w_bin_next[gi+1];
      end
   endgenerate
   assign w_gray_next[WIDTH-1] = w_bin_next[WIDTH-1];

   // Control FSM with registered counter, code, status and wrap outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_bin    <= '0;
         r_gray   <= '0;
         r_presc  <= '0;
         r_active <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_wrap <= 1'b0;
               if (enable) begin
                  // Load a full period so div=0 steps on the edge after entry.
                  r_state  <= RUN;
                  r_presc  <= div;
                  r_active <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               r_bin   <= w_bin_next;
               r_gray  <= w_gray_next;
               r_presc <= w_presc_next;
               r_wrap  <= w_wrap_next;
               if (enable) begin
                  // Re-enable from DRAIN resumes without touching the countdown.
                  r_state  <= RUN;
                  r_active <= 1'b1;
               end else if (w_bin_next == '0) begin
                  r_state  <= IDLE;
                  r_active <= 1'b0;
               end else begin
                  r_state  <= DRAIN;
                  r_active <= 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_active <= 1'b0;
               r_wrap   <= 1'b0;
            end
         endcase
      end
   end

   assign gray_out   = r_gray;
   assign bin_out    = r_bin;
   assign active     = r_active;
   assign wrap_pulse = r_wrap;

endmodule
